stage_loader: RTL and testbench

//  Sequences the stage ROM at level start: reads all brick rows of the selected stage,

---
 rtl/stage_loader_if.sv | 37 +++
 rtl/stage_loader.sv | 131 +++++++++++++
 tb/tb_stage_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage_loader_if.sv
// stage_loader_if: groups the loader's game-FSM handshake, stage ROM read port and
// brick-map RAM write port. The loader connects through "master"; the game FSM,
// ROM and RAM side connects through "slave".
interface stage_loader_if #(
    parameter int ROW_W = 30,
    parameter int AW    = 5,
    parameter int SW    = 2,
    parameter int CNT_W = 9
);
    logic             load_req;
    logic [SW-1:0]    load_stage;
    logic             busy;
    logic             done;
    logic             load_err;
    logic             rom_enable;
    logic [AW-1:0]    rom_addr;
    logic [SW-1:0]    rom_stage;
    logic [ROW_W-1:0] rom_data;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [ROW_W-1:0] wr_data;
    logic             brick_hit;
    logic [CNT_W-1:0] bricks_left;
    logic             stage_clear;

    modport master (
        input  load_req, load_stage, rom_data, brick_hit,
        output busy, done, load_err, rom_enable, rom_addr, rom_stage,
               wr_en, wr_addr, wr_data, bricks_left, stage_clear
    );

    modport slave (
        output load_req, load_stage, rom_data, brick_hit,
        input  busy, done, load_err, rom_enable, rom_addr, rom_stage,
               wr_en, wr_addr, wr_data, bricks_left, stage_clear
    );
endinterface

// File: rtl/stage_loader.sv
// stage_loader: at level start copies every row of the selected stage ROM into the
// brick-map RAM while counting breakable bricks, then tracks remaining bricks on
// ball hits and pulses stage_clear when the last one goes.
// Optional feature: define STAGE_LOADER_UNBREAKABLE_EN to treat code 3'b111 as an
// unbreakable brick (still written to the map, never counted).
module stage_loader #(
    parameter int ROWS       = 30,
    parameter int COLS       = 10,
    parameter int NUM_STAGES = 1,
    parameter int CNT_W      = 9
) (
    input  logic           clock,
    input  logic           reset_n,
    stage_loader_if.master bus
);
    localparam int             ROW_W    = 3 * COLS;
    localparam int             AW       = 5;
    localparam int             PC_W     = $clog2(COLS + 1);
    localparam logic [AW-1:0]  LAST_ROW = AW'(ROWS - 1);
    localparam logic [2:0]     NSTG     = 3'(NUM_STAGES);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t            state;
    logic [AW-1:0]     rd_row;
    logic              vld_p1;
    logic [AW-1:0]     rd_addr_p1;
    logic              stage_ok;
    logic              accept;

    // Number of breakable brick codes in one row (parallel compare + adder tree).
    function automatic logic [PC_W-1:0] count_breakable(input logic [ROW_W-1:0] row);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < COLS; i++) begin
`ifdef STAGE_LOADER_UNBREAKABLE_EN
            if (row[3*i +: 3] != 3'b000 && row[3*i +: 3] != 3'b111) n = n + 1'b1;
`else
            if (row[3*i +: 3] != 3'b000) n = n + 1'b1;
`endif
        end
        return n;
    endfunction

    // Brick counter decrement that sticks at zero instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    assign stage_ok = ({1'b0, bus.load_stage} < NSTG);
    assign accept   = (state == IDLE) && bus.load_req && stage_ok;

    // Control FSM: accepts loads, issues one ROM row read per cycle, raises done/load_err.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rd_row        <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.load_err  <= 1'b0;
            bus.rom_enable <= 1'b0;
            bus.rom_addr  <= '0;
            bus.rom_stage <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.load_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load_req) begin
                        if (stage_ok) begin
                            bus.rom_stage <= bus.load_stage;
                            rd_row        <= '0;
                            bus.busy      <= 1'b1;
                            state         <= READ;
                        end else begin
                            bus.load_err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    bus.rom_enable <= 1'b1;
                    bus.rom_addr   <= rd_row;
                    rd_row         <= rd_row + 1'b1;
                    if (rd_row == LAST_ROW) state <= DRAIN;
                end
                DRAIN: begin
                    bus.rom_enable <= 1'b0;
                    // The final row's write is visible on the RAM port this cycle.
                    if (bus.wr_en && bus.wr_addr == LAST_ROW) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= FIN;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read pipeline: p1 aligns valid/row with ROM latency, then the row is written and counted;
    // in IDLE the same counter tracks brick hits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1          <= 1'b0;
            rd_addr_p1      <= '0;
            bus.wr_en       <= 1'b0;
            bus.wr_addr     <= '0;
            bus.wr_data     <= '0;
            bus.bricks_left <= '0;
            bus.stage_clear <= 1'b0;
        end else begin
            vld_p1          <= bus.rom_enable;
            rd_addr_p1      <= bus.rom_addr;
            bus.wr_en       <= vld_p1;
            bus.stage_clear <= 1'b0;
            if (vld_p1) begin
                bus.wr_addr <= rd_addr_p1;
                bus.wr_data <= bus.rom_data;
            end
            if (accept) begin
                bus.bricks_left <= '0;
            end else if (vld_p1) begin
                bus.bricks_left <= bus.bricks_left + CNT_W'(count_breakable(bus.rom_data));
            end else if (state == IDLE && bus.brick_hit && bus.bricks_left != '0) begin
                bus.bricks_left <= sat_dec(bus.bricks_left);
                bus.stage_clear <= (bus.bricks_left == CNT_W'(1));
            end
        end
    end
endmodule

// File: tb/tb_stage_loader.sv
// tb_stage_loader: directed sequence of loads, invalid loads, brick hits and a
// mid-load reset, checked against a row-level model of the loader.
module tb_stage_loader;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    stage_loader_if bus ();
    stage_loader dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    logic [29:0] img [0:31];
    int vectors = 0;
    int miscompares = 0;

    // Stage ROM: registered read; garbage on the data bus when not enabled.
    always @(posedge clock)
        bus.rom_data <= bus.rom_enable ? img[bus.rom_addr] : 30'($urandom);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Breakable bricks in the current image, straight from the brick code rules.
    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 10; c++) begin
                logic [2:0] code;
                code = img[r][3*c +: 3];
`ifdef STAGE_LOADER_UNBREAKABLE_EN
                if (code != 3'b000 && code != 3'b111) n++;
`else
                if (code != 3'b000) n++;
`endif
            end
        return n;
    endfunction

    // One full load of stage 0; optional noise (hits, loads) while busy.
    task automatic load_and_check(input int exp_cnt, input bit inject);
        int first_wr = -1, done_cyc = -1, done_n = 0, row = 0, bad_busy = 0, bad_en = 0;
        logic exp_busy, exp_en;
        @(negedge clock);
        bus.load_req = 1'b1;
        bus.load_stage = 2'd0;
        bus.brick_hit = inject;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clock);
            if (c == 0) begin
                chk("cnt_cleared_on_load", 32'(bus.bricks_left), 0);
                chk("rom_stage", 32'(bus.rom_stage), 0);
            end
            exp_busy = (c < 33);
            exp_en = (c >= 1 && c <= 30);
            if (bus.busy !== exp_busy) bad_busy++;
            if (bus.rom_enable !== exp_en || (exp_en && bus.rom_addr !== 5'(c - 1))) bad_en++;
            if (bus.wr_en) begin
                if (first_wr < 0) first_wr = c;
                chk("wr_addr", 32'(bus.wr_addr), row);
                if (row < 32) chk("wr_data", 32'(bus.wr_data), 32'(img[row]));
                row++;
            end
            if (bus.done) begin
                done_n++;
                done_cyc = c;
            end
            if (inject && c >= 1 && c < 30) begin
                bus.load_req = 1'($urandom_range(0, 1));
                bus.load_stage = 2'($urandom_range(0, 3));
                bus.brick_hit = 1'($urandom_range(0, 1));
            end else begin
                bus.load_req = 1'b0;
                bus.load_stage = 2'd0;
                bus.brick_hit = 1'b0;
            end
        end
        chk("first_wr_cycle", first_wr, 3);
        chk("write_count", row, 30);
        chk("done_cycle", done_cyc, 33);
        chk("done_pulses", done_n, 1);
        chk("busy_errors", bad_busy, 0);
        chk("rom_enable_errors", bad_en, 0);
        chk("bricks_left_final", 32'(bus.bricks_left), exp_cnt);
    endtask

    initial begin
        int exp, found, bad;
        logic [8:0] prev;
        bus.load_req = 1'b0;
        bus.load_stage = 2'd0;
        bus.brick_hit = 1'b0;
        for (int i = 0; i < 32; i++) img[i] = '0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_load_err", 32'(bus.load_err), 0);
        chk("rst_rom_enable", 32'(bus.rom_enable), 0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 0);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        chk("rst_bricks_left", 32'(bus.bricks_left), 0);
        chk("rst_stage_clear", 32'(bus.stage_clear), 0);
        reset_n = 1'b1;

        // Directed stage 0 image: 3 empty cells, 4 code-7 cells, rest codes 1..6
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 10; c++) img[r][3*c +: 3] = 3'(1 + (r * 7 + c * 3) % 6);
        img[0][2:0] = 3'd0;
        img[5][11:9] = 3'd0;
        img[29][29:27] = 3'd0;
        img[1][5:3] = 3'd7;
        img[10][14:12] = 3'd7;
        img[20][23:21] = 3'd7;
        img[28][8:6] = 3'd7;
`ifdef STAGE_LOADER_UNBREAKABLE_EN
        exp = 293;
`else
        exp = 297;
`endif
        chk("model_directed_count", model_count(), exp);
        load_and_check(exp, 1'b0);

        // Out-of-range stage request
        @(negedge clock);
        prev = bus.bricks_left;
        bus.load_req = 1'b1;
        bus.load_stage = 2'($urandom_range(1, 3));
        @(negedge clock);
        bus.load_req = 1'b0;
        chk("err_pulse", 32'(bus.load_err), 1);
        chk("err_busy", 32'(bus.busy), 0);
        chk("err_rom_enable", 32'(bus.rom_enable), 0);
        @(negedge clock);
        chk("err_pulse_end", 32'(bus.load_err), 0);
        chk("err_rom_enable2", 32'(bus.rom_enable), 0);
        chk("err_busy2", 32'(bus.busy), 0);
        chk("err_bricks_kept", 32'(bus.bricks_left), 32'(prev));

        // Load with simultaneous hit, then hits/loads while busy: all ignored
        load_and_check(exp, 1'b1);

        // Random image load, then hits down to zero
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 10; c++) img[r][3*c +: 3] = 3'($urandom_range(0, 7));
        img[0][2:0] = 3'd1;
        exp = model_count();
        load_and_check(exp, 1'b0);
        while (exp > 1) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            bus.brick_hit = 1'b1;
            @(negedge clock);
            bus.brick_hit = 1'b0;
            exp--;
            chk("hit_decrement", 32'(bus.bricks_left), exp);
            chk("hit_no_clear", 32'(bus.stage_clear), 0);
        end
        bus.brick_hit = 1'b1;
        @(negedge clock);
        bus.brick_hit = 1'b0;
        chk("last_hit_zero", 32'(bus.bricks_left), 0);
        chk("last_hit_clear", 32'(bus.stage_clear), 1);
        @(negedge clock);
        chk("clear_pulse_end", 32'(bus.stage_clear), 0);
        bus.brick_hit = 1'b1;
        @(negedge clock);
        bus.brick_hit = 1'b0;
        chk("hit_at_zero", 32'(bus.bricks_left), 0);
        chk("hit_at_zero_clear", 32'(bus.stage_clear), 0);

        // Reset mid-READ at row 12
        @(negedge clock);
        bus.load_req = 1'b1;
        bus.load_stage = 2'd0;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            @(negedge clock);
            bus.load_req = 1'b0;
            if (bus.rom_enable === 1'b1 && bus.rom_addr === 5'd12) found = 1;
        end
        chk("reached_row12", found, 1);
        reset_n = 1'b0;
        #1;
        chk("abort_rom_enable", 32'(bus.rom_enable), 0);
        chk("abort_wr_en", 32'(bus.wr_en), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_bricks_left", 32'(bus.bricks_left), 0);
        @(negedge clock);
        chk("abort_next_rom_enable", 32'(bus.rom_enable), 0);
        chk("abort_next_wr_en", 32'(bus.wr_en), 0);
        chk("abort_next_busy", 32'(bus.busy), 0);
        chk("abort_next_bricks_left", 32'(bus.bricks_left), 0);
        bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (bus.rom_enable !== 1'b0 || bus.wr_en !== 1'b0) bad++;
        end
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (bus.rom_enable !== 1'b0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        chk("no_activity_after_abort", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
